banco_registradores_sb: RTL



---
 rtl/banco_pkg.sv | 11 +
 rtl/placar_registradores.sv | 40 ++++
 rtl/banco_registradores_sb.sv | 59 +++++
 3 files changed

// File: rtl/banco_pkg.sv
// banco_pkg: shared defaults and helpers for the register bank with scoreboard.
package banco_pkg;
    localparam int DATA_W_PADRAO = 16;
    localparam int ADDR_W_PADRAO = 4;
    localparam bit ZERO_REG_PADRAO = 1'b0;

    // The counter must hold NUM_REGS itself, hence one bit more than the address.
    function automatic int largura_contador(input int addr_w);
        return addr_w + 1;
    endfunction
endpackage

// File: rtl/placar_registradores.sv
// placar_registradores: pending-write scoreboard bits with a registered popcount.
module placar_registradores
    import banco_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_PADRAO,
    parameter bit ZERO_REG = ZERO_REG_PADRAO,
    localparam int N = 2**ADDR_W,
    localparam int CW = largura_contador(ADDR_W)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          set_en,
    input  logic [ADDR_W-1:0] set_idx,
    input  logic          clr_en,
    input  logic [ADDR_W-1:0] clr_idx,
    output logic [N-1:0]  placar,
    output logic [CW-1:0] num_pendentes
);
    logic [N-1:0]  prox;
    logic [CW-1:0] soma;

    // Set is applied after clear so a new producer reserving the register wins.
    always_comb begin
        prox = placar;
        if (clr_en && !(ZERO_REG && clr_idx == '0)) prox[clr_idx] = 1'b0;
        if (set_en && !(ZERO_REG && set_idx == '0)) prox[set_idx] = 1'b1;
        soma = '0;
        for (int i = 0; i < N; i++) soma = soma + CW'(prox[i]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            placar        <= '0;
            num_pendentes <= '0;
        end else begin
            placar        <= prox;
            num_pendentes <= soma;
        end
    end
endmodule

// File: rtl/banco_registradores_sb.sv
// banco_registradores_sb: 2-read/1-write register file with write-first bypass,
// optional hardwired r0 and a pending-write scoreboard for RAW stalls.
module banco_registradores_sb
    import banco_pkg::*;
#(
    parameter int DATA_W = DATA_W_PADRAO,
    parameter int ADDR_W = ADDR_W_PADRAO,
    parameter bit ZERO_REG = ZERO_REG_PADRAO
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] regA,
    input  logic [ADDR_W-1:0] regB,
    input  logic [ADDR_W-1:0] regC,
    input  logic [DATA_W-1:0] dado,
    input  logic              RW,
    input  logic              reserva_en,
    input  logic [ADDR_W-1:0] regR,
    output logic [DATA_W-1:0] regsaidaA,
    output logic [DATA_W-1:0] regsaidaB,
    output logic              pendenteA,
    output logic              pendenteB,
    output logic [ADDR_W:0]   num_pendentes
);
    localparam int NUM_REGS = 2**ADDR_W;

    logic [DATA_W-1:0]   regs [NUM_REGS];
    logic [NUM_REGS-1:0] placar;
    logic                escreve;

    assign escreve = RW && !(ZERO_REG && regC == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else if (escreve) begin
            regs[regC] <= dado;
        end
    end

    placar_registradores #(.ADDR_W(ADDR_W), .ZERO_REG(ZERO_REG)) u_placar (
        .clk          (clk),
        .rst          (rst),
        .set_en       (reserva_en),
        .set_idx      (regR),
        .clr_en       (RW),
        .clr_idx      (regC),
        .placar       (placar),
        .num_pendentes(num_pendentes)
    );

    // A same-cycle writeback resolves the hazard: the consumer takes the bypassed value.
    always_comb begin
        regsaidaA = (ZERO_REG && regA == '0) ? '0 : (RW && regC == regA) ? dado : regs[regA];
        regsaidaB = (ZERO_REG && regB == '0) ? '0 : (RW && regC == regB) ? dado : regs[regB];
        pendenteA = placar[regA] && !(RW && regC == regA);
        pendenteB = placar[regB] && !(RW && regC == regB);
    end
endmodule
